// File: rtl/fifo_pkg.sv
// Shared types, defaults and helpers for the FIFO read-side drain controller.
package fifo_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned READ_LAT_DEF   = 2;
    localparam int unsigned BUF_DEPTH_DEF  = 4;

    typedef logic [DATA_WIDTH_DEF-1:0] data_t;

    // Ceiling log2, usable in constant expressions for widths.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = unsigned'(i) + 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/drain_buf.sv
// Small circular buffer with push/pop, occupancy and a first-word-fall-through head.
module drain_buf
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned BUF_DEPTH  = BUF_DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push_i,
    input  logic [DATA_WIDTH-1:0]     push_data_i,
    input  logic                      pop_i,
    output logic [DATA_WIDTH-1:0]     head_o,
    output logic [clog2(BUF_DEPTH):0] occ_o
);

    localparam int unsigned PTR_W = clog2(BUF_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]      occ_q, occ_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_i, pop_i})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Storage is cleared on reset so the head reads zero while empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) mem_q[i] <= '0;
        end else begin
            if (push_i) mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push_i && occ_q == OCC_W'(BUF_DEPTH)))
                else $error("drain_buf: push into full buffer");
            assert (!(pop_i && occ_q == '0))
                else $error("drain_buf: pop from empty buffer");
        end
    end

    assign head_o = mem_q[rd_ptr_q];
    assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Read-side FIFO drain controller: credit-gated RDEN, read-latency tracker, valid/ready output.
// Optional macro DRAIN_STAT_EN adds a saturating accepted-word counter output word_cnt.
module fifo_drain_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned READ_LAT   = READ_LAT_DEF,
    parameter int unsigned BUF_DEPTH  = BUF_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    output logic                  fifo_rden,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy
`ifdef DRAIN_STAT_EN
    ,
    output logic [15:0]           word_cnt
`endif
);

    localparam int unsigned OCC_W = clog2(BUF_DEPTH) + 1;
    localparam int unsigned SUM_W = clog2(BUF_DEPTH + READ_LAT + 1) + 1;

    logic [READ_LAT-1:0] tracker_q, tracker_d;
    logic [SUM_W-1:0]    inflight;
    logic [SUM_W-1:0]    outstanding;
    logic [OCC_W-1:0]    occ;
    logic                push;
    logic                pop;

    // Tracker bit i set means a read issued i+1 edges ago is still travelling.
    always_comb begin
        tracker_d    = '0;
        tracker_d[0] = fifo_rden;
        for (int i = 1; i < int'(READ_LAT); i++) tracker_d[i] = tracker_q[i-1];
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(READ_LAT); i++) inflight = inflight + SUM_W'(tracker_q[i]);
    end

    always_ff @(posedge clk) begin
        if (reset) tracker_q <= '0;
        else       tracker_q <= tracker_d;
    end

    // Credit counts only registered state, so a same-cycle pop never frees a slot early.
    assign outstanding = SUM_W'(occ) + inflight;
    assign fifo_rden   = !fifo_empty && (outstanding < SUM_W'(BUF_DEPTH)) && !reset;

    assign push      = tracker_q[READ_LAT-1];
    assign out_valid = (occ != '0);
    assign pop       = out_valid && out_ready;
    assign busy      = out_valid || (|tracker_q);

    drain_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (fifo_data),
        .pop_i       (pop),
        .head_o      (out_data),
        .occ_o       (occ)
    );

`ifdef DRAIN_STAT_EN
    logic [15:0] word_cnt_q;

    always_ff @(posedge clk) begin
        if (reset)                             word_cnt_q <= '0;
        else if (pop && word_cnt_q != 16'hFFFF) word_cnt_q <= word_cnt_q + 16'd1;
    end

    assign word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: FIFO model with read latency, credit/scoreboard reference, directed and random steps.
module tb_fifo_drain_ctrl;

    localparam int DW = 8;
    localparam int RL = 2;
    localparam int BD = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fifo_empty;
    logic          fifo_rden;
    logic [DW-1:0] fifo_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          busy;
`ifdef DRAIN_STAT_EN
    logic [15:0]   word_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fifo_drain_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_rden  (fifo_rden),
        .fifo_data  (fifo_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
`ifdef DRAIN_STAT_EN
        ,
        .word_cnt   (word_cnt)
`endif
    );

    // Upstream FIFO model: array storage, data appears RL edges after a sampled read.
    logic [DW-1:0] fmem [1024];
    int            wr_idx = 0;
    int            rd_idx = 0;
    logic [DW-1:0] pipe [RL];

    assign fifo_empty = (wr_idx == rd_idx);
    assign fifo_data  = pipe[RL-1];

    always @(posedge clk) begin
        if (fifo_rden) rd_idx <= rd_idx + 1;
        pipe[0] <= fifo_rden ? fmem[rd_idx % 1024] : 8'($urandom);
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fpush(input logic [DW-1:0] d);
        fmem[wr_idx % 1024] = d;
        wr_idx++;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference: words read but not yet accepted never exceed the buffer depth,
    // and accepted words come out in FIFO read order.
    int            issued = 0;
    int            accepted = 0;
    logic [DW-1:0] expq [$];
    bit            mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("rden", fifo_rden, !reset && (wr_idx != rd_idx) && (issued - accepted < BD));
            chk("busy", busy, (issued - accepted) != 0);
            if (reset) begin
                issued   = 0;
                accepted = 0;
                expq.delete();
            end else begin
                if (fifo_rden) begin
                    expq.push_back(fmem[rd_idx % 1024]);
                    issued++;
                end
                if (out_valid && out_ready) begin
                    chk("pop_has_word", expq.size() != 0, 1'b1);
                    if (expq.size() != 0) chk("data", out_data, expq.pop_front());
                    accepted++;
                end
            end
        end
    end

    initial begin
        int fr, fv, lv, nv, nr, acc0, pc, busy_after, seen07;
        logic [DW-1:0] d1;
        bit done;

        // Reset held with a non-empty FIFO: nothing moves.
        for (int i = 1; i <= 16; i++) fpush(DW'(i));
        next_cycle();
        mon_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_rden", fifo_rden, 1'b0);
            chk("rst_valid", out_valid, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_data", out_data, 8'h00);
            next_cycle();
        end

        // Streaming with ready held high.
        reset = 1'b0;
        out_ready = 1'b1;
        fr = -1; fv = -1; lv = -1; nv = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (fifo_rden && fr < 0) fr = c;
            if (out_valid) begin
                if (fv < 0) fv = c;
                lv = c;
                nv++;
            end
            next_cycle();
        end
        chk("first_rden_cycle", fr, 0);
        chk("first_valid_latency", fv - fr, 3);
        chk("stream_beats", nv, 16);
        chk("stream_contiguous", lv - fv, 15);

        // Random traffic with random backpressure.
        for (int c = 0; c < 300; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0 && (wr_idx - rd_idx) < 200) fpush(8'($urandom));
            next_cycle();
        end
        out_ready = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            done = fifo_empty && !busy;
            next_cycle();
        end
        chk("random_drained", done, 1'b1);

        // Backpressure: buffer fills to depth, then releases in order.
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        out_ready = 1'b0;
        for (int i = 1; i <= 16; i++) fpush(DW'(i));
        nr = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (fifo_rden) nr++;
            next_cycle();
        end
        @(negedge clk);
        chk("bp_rden_pulses", nr, 4);
        chk("bp_rden_held", fifo_rden, 1'b0);
        chk("bp_valid", out_valid, 1'b1);
        chk("bp_head", out_data, 8'h01);
        next_cycle();
        acc0 = accepted;
        out_ready = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            done = fifo_empty && !busy;
            next_cycle();
        end
        chk("bp_drained", done, 1'b1);
        chk("bp_delivered", accepted - acc0, 16);

        // Single word: one read, one beat, busy drops right after the pop.
        fpush(8'hA5);
        nr = 0; nv = 0; pc = -1; busy_after = -1; d1 = '0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (fifo_rden) nr++;
            if (pc >= 0 && c == pc + 1) busy_after = int'(busy);
            if (out_valid) begin
                nv++;
                pc = c;
                d1 = out_data;
            end
            next_cycle();
        end
        chk("single_rden", nr, 1);
        chk("single_beats", nv, 1);
        chk("single_data", d1, 8'hA5);
        chk("single_busy_after_pop", busy_after, 0);

        // Reset one cycle after the read of 0x07: that word must never surface.
        fpush(8'h07);
        done = 1'b0;
        for (int c = 0; c < 5 && !done; c++) begin
            @(negedge clk);
            done = fifo_rden;
            next_cycle();
        end
        chk("midflight_rden_seen", done, 1'b1);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        nv = 0; seen07 = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) nv++;
            if (out_valid && out_data == 8'h07) seen07++;
            if (c == 0) chk("midflight_busy", busy, 1'b0);
            next_cycle();
        end
        chk("midflight_valid_beats", nv, 0);
        chk("midflight_07_seen", seen07, 0);

`ifdef DRAIN_STAT_EN
        // Counter saturates after more than 65535 accepted words.
        out_ready = 1'b1;
        acc0 = accepted;
        for (int c = 0; c < 72000 && (accepted - acc0) < 70000; c++) begin
            if ((wr_idx - rd_idx) < 8) fpush(8'($urandom));
            next_cycle();
        end
        @(negedge clk);
        chk("stat_pops", (accepted - acc0) >= 70000, 1'b1);
        chk("stat_saturated", word_cnt, 16'hFFFF);
        next_cycle();
        @(negedge clk);
        chk("stat_hold", word_cnt, 16'hFFFF);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("stat_reset", word_cnt, 16'h0000);
        next_cycle();
        reset = 1'b0;
`endif

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
